// File: rtl/fnd_scan_if.sv
// Bus between an FND value producer and the scan controller.
// i_load is a request that is taken on a clock edge only while o_busy is low; while busy it is dropped, not queued.
interface fnd_scan_if;
  logic [13:0] i_value;
  logic        i_load;
  logic        i_blank_lz;
  logic        o_busy;
  logic        o_overflow;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_value;
  logic        o_en;

  modport master (
    output i_value, i_load, i_blank_lz,
    input  o_busy, o_overflow, o_digitSelect, o_value, o_en
  );

  modport slave (
    input  i_value, i_load, i_blank_lz,
    output o_busy, o_overflow, o_digitSelect, o_value, o_en
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD via sequential double dabble, with a 4-digit time-multiplexed scan
// that drives an FND select/font decoder.
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100000,
  parameter int BIN_W    = 14
) (
  input  logic       i_clk,
  input  logic       i_reset,
  fnd_scan_if.slave  bus,
  output logic [1:0] o_dbg_state
);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state_q;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  cnt_q;
  logic        ovf_pend_q;
  logic        busy_q;
  logic        ovf_q;
  logic [15:0] disp_q;
  logic [PW-1:0] presc_q;
  logic [1:0]  digit_q;
  logic        blank_q;

  logic [13:0] value_sat;
  logic [14:0] bcd_adj;
  logic [3:1]  nz;
  logic [3:0]  lead;

  assign value_sat = (bus.i_value > 14'd9999) ? 14'd9999 : bus.i_value;

  // Nibble 3 never exceeds 4 before a shift (final value <= 9), so it needs no adjust.
  always_comb begin
    bcd_adj = bcd_q[14:0];
    for (int k = 0; k < 3; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_load) begin
            bin_q      <= value_sat;
            bcd_q      <= '0;
            cnt_q      <= 4'(BIN_W);
            ovf_pend_q <= (bus.i_value > 14'd9999);
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= {bcd_adj, bin_q[13]};
          bin_q <= {bin_q[12:0], 1'b0};
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= COMMIT;
        end
        COMMIT: begin
          disp_q  <= bcd_q;
          ovf_q   <= ovf_pend_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Free-running scan; commits do not disturb the digit phase.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_q <= '0;
      digit_q <= '0;
      blank_q <= 1'b0;
    end else begin
      blank_q <= bus.i_blank_lz;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        digit_q <= digit_q + 2'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign nz   = {disp_q[15:12] != 4'd0, disp_q[11:8] != 4'd0, disp_q[7:4] != 4'd0};
  assign lead = {nz[3], |nz[3:2], |nz[3:1], 1'b1};

  assign bus.o_busy        = busy_q;
  assign bus.o_overflow    = ovf_q;
  assign bus.o_digitSelect = digit_q;
  assign bus.o_value       = disp_q[{digit_q, 2'b00} +: 4];
  assign bus.o_en          = !blank_q || lead[digit_q];
  assign o_dbg_state       = state_q;
endmodule
